bus_arbiter_8: RTL and testbench

BUS_ARBITER_8 -- requirements
Module: bus_arbiter_8

---
 rtl/bus_arbiter_8_pkg.sv | 29 ++
 rtl/DECODER_3.sv | 9 +
 rtl/bus_arbiter_8.sv | 109 ++++++++++
 tb/tb_bus_arbiter_8.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_8_pkg.sv
// Shared constants for the 8-way rotating-priority bus arbiter: requester count, state codes,
// HOLD_MAX default and the rotating priority search. Imported by the block and its bench.
package bus_arbiter_8_pkg;

  localparam int unsigned BA8_N_REQ            = 8;
  localparam int unsigned BA8_IDX_W            = 3;
  localparam int unsigned BA8_HOLD_MAX_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // First set request bit in the order ptr, ptr+1, ... ptr+7 (mod 8).
  function automatic logic [BA8_IDX_W-1:0] ba8_pick(input logic [BA8_N_REQ-1:0] req,
                                                    input logic [BA8_IDX_W-1:0] ptr);
    logic [BA8_IDX_W-1:0] idx;
    logic                 found;
    ba8_pick = ptr;
    found    = 1'b0;
    for (int i = 0; i < int'(BA8_N_REQ); i++) begin
      idx = ptr + BA8_IDX_W'(i);
      if (!found && req[idx]) begin
        ba8_pick = idx;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/DECODER_3.sv
// Existing 3-to-8 one-hot decoder, reused by the arbiter to form its grant vector.
module DECODER_3 (
  input  logic [2:0] sel,
  output logic [7:0] dec
);

  assign dec = 8'(1) << sel;

endmodule

// File: rtl/bus_arbiter_8.sv
// 8-requester rotating-priority bus arbiter with a one-cycle GAP between owners.
// Define BUS_ARBITER_TIMEOUT_EN to force-revoke a grant after HOLD_MAX cycles.
module bus_arbiter_8
  import bus_arbiter_8_pkg::*;
#(
  parameter int unsigned HOLD_MAX = BA8_HOLD_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("bus_arbiter_8: HOLD_MAX must be in 2..255");
  end

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [BA8_IDX_W-1:0] r_ptr;
  logic [BA8_IDX_W-1:0] w_ptr_nxt;
  logic [BA8_IDX_W-1:0] r_idx;
  logic [BA8_IDX_W-1:0] w_idx_nxt;
  logic                 r_timeout;
  logic                 w_timeout_nxt;
  logic [BA8_IDX_W-1:0] w_winner;
  logic                 w_hold_expire;
  logic [BA8_N_REQ-1:0] w_dec;

  assign w_winner = ba8_pick(req, r_ptr);

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] r_hold_cnt;

  // Counts completed grant cycles of the current owner; zero outside GRANT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else if (r_state != ST_GRANT) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= r_hold_cnt + CNT_W'(1);
    end
  end

  assign w_hold_expire = (r_hold_cnt == CNT_W'(HOLD_MAX - 1));
`else
  assign w_hold_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_idx     <= w_idx_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // A voluntary drop wins over an expiring hold on the same edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_winner;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[r_idx]) begin
          w_state_nxt = ST_GAP;
          w_ptr_nxt   = r_idx + BA8_IDX_W'(1);
        end else if (w_hold_expire) begin
          w_state_nxt   = ST_GAP;
          w_ptr_nxt     = r_idx + BA8_IDX_W'(1);
          w_timeout_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  DECODER_3 u_dec (
    .sel (r_idx),
    .dec (w_dec)
  );

  assign busy    = (r_state == ST_GRANT);
  assign gnt     = w_dec & {BA8_N_REQ{busy}};
  assign gnt_idx = r_idx;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Directed bench for bus_arbiter_8 with an owner-based reference model checked every cycle.
module tb_bus_arbiter_8;
  import bus_arbiter_8_pkg::*;

  localparam int HOLD = 4;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int n_vec;
  int n_err;

  bus_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 = nobody), last owner, search start, hold time.
  int  m_owner;
  int  m_last;
  int  m_ptr;
  int  m_hold;
  bit  m_to;
  bit  m_valid;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic bit hold_limit_on();
`ifdef BUS_ARBITER_TIMEOUT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_to = 0; m_valid = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_to = 0; m_valid = 1;
    end else if (m_owner >= 0) begin
      m_to = 0;
      if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else if (hold_limit_on() && (m_hold + 1 == HOLD)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = 1;
      end else begin
        m_hold++;
      end
    end else begin
      // Nobody owns the bus: the cycle after a release is the gap, so arbitration is the same as idle.
      m_to = 0;
      if (req != 8'h00) begin
        m_owner = pick(req, m_ptr);
        m_last  = m_owner;
        m_hold  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("model_idx", 32'(gnt_idx), 32'(m_last));
      chk("model_busy", 32'(busy), 32'(m_owner >= 0));
      chk("model_timeout", 32'(timeout), 32'(m_to));
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("gnt_vs_idx", 32'(gnt), busy ? (32'd1 << gnt_idx) : 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    req   = 8'h00;
    cyc(2);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;

    // Single requester grant, drop, gap, idle.
    req = 8'b0000_0100;
    cyc(1);
    chk("single_gnt", 32'(gnt), 32'h04);
    chk("single_idx", 32'(gnt_idx), 32'd2);
    chk("single_busy", 32'(busy), 32'd1);
    req = 8'h00;
    cyc(1);
    chk("single_gap_gnt", 32'(gnt), 32'h00);
    chk("single_gap_idx", 32'(gnt_idx), 32'd2);
    cyc(1);
    chk("single_idle_gnt", 32'(gnt), 32'h00);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // All requesting: each owner holds 3 cycles, drops and re-raises; order wraps 0..7,0.
    do_reset();
    req = 8'hFF;
    cyc(1);
    chk("rr_first", 32'(gnt), 32'h01);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] drop_mask;
      logic [7:0] exp_next;
      drop_mask = 8'h01 << k;
      exp_next  = 8'h01 << ((k + 1) % 8);
      cyc(2);
      chk("rr_hold", 32'(gnt), 32'(drop_mask));
      req = 8'hFF & ~drop_mask;
      cyc(1);
      chk("rr_gap", 32'(gnt), 32'h00);
      req = 8'hFF;
      cyc(1);
      chk("rr_next", 32'(gnt), 32'(exp_next));
    end
    req = 8'h00;
    cyc(2);

    // Owner 5 with 1 and 6 waiting; rotation after 5 reaches 6 first.
    do_reset();
    req = 8'b0010_0000;
    cyc(1);
    chk("rot_owner5", 32'(gnt), 32'h20);
    req = 8'b0110_0010;
    cyc(2);
    chk("rot_ignore_others", 32'(gnt), 32'h20);
    req = 8'b0100_0010;
    cyc(1);
    chk("rot_gap", 32'(gnt), 32'h00);
    cyc(1);
    chk("rot_gnt6", 32'(gnt), 32'h40);
    chk("rot_idx6", 32'(gnt_idx), 32'd6);
    req = 8'h00;
    cyc(2);

    // Owner 3 holds forever with 4 waiting: forced revoke only when the hold limit is built in.
    do_reset();
    req = 8'b0001_1000;
    cyc(1);
    chk("hold_first", 32'(gnt), 32'h08);
    cyc(3);
    chk("hold_last", 32'(gnt), 32'h08);
    cyc(1);
`ifdef BUS_ARBITER_TIMEOUT_EN
    chk("hold_revoke_gnt", 32'(gnt), 32'h00);
    chk("hold_revoke_to", 32'(timeout), 32'd1);
    cyc(1);
    chk("hold_next_gnt", 32'(gnt), 32'h10);
    chk("hold_next_to", 32'(timeout), 32'd0);
`else
    chk("hold_keep_gnt", 32'(gnt), 32'h08);
    chk("hold_keep_to", 32'(timeout), 32'd0);
    cyc(20);
    chk("hold_keep_long", 32'(gnt), 32'h08);
`endif
    req = 8'h00;
    cyc(2);

    // Reset during grant of 6 (pointer moved to 4 beforehand): no gap, search restarts at 0.
    do_reset();
    req = 8'b0000_1000;
    cyc(1);
    req = 8'h00;
    cyc(2);
    req = 8'hC0;
    cyc(1);
    chk("rstmid_before", 32'(gnt), 32'h40);
    reset = 1'b1;
    cyc(1);
    chk("rstmid_gnt", 32'(gnt), 32'h00);
    chk("rstmid_idx", 32'(gnt_idx), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_to", 32'(timeout), 32'h0);
    reset = 1'b0;
    cyc(1);
    chk("rstmid_after", 32'(gnt), 32'h40);
    req = 8'b1000_0001;
    cyc(1);
    chk("rstmid_gap", 32'(gnt), 32'h00);
    cyc(1);
    chk("rstmid_wrap", 32'(gnt), 32'h80);
    req = 8'h00;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
